// File: rtl/scu_dsp_dma_mc_pkg.sv
// Shared command/state types and the address-increment decode for the multi-channel DSP DMA.
package scu_dsp_dma_mc_pkg;

  // Command fields are sized for the largest supported bank/count configuration.
  localparam int CMD_BANK_W = 4;
  localparam int CMD_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } DMAState_t;

  // CNT holds the live remaining word count; a start count of 0 is loaded as 2^CNT_W.
  typedef struct packed {
    logic                  DIR;
    logic                  HOLD;
    logic [2:0]            ADDI;
    logic [CMD_BANK_W-1:0] BANK;
    logic [CMD_CNT_W-1:0]  CNT;
  } DMACmd_t;

  function automatic logic [8:0] DMAAddrAdd(input logic [2:0] addi);
    return (addi == 3'd0) ? 9'd0 : (9'd2 << addi);
  endfunction

endpackage

// File: rtl/scu_dsp_dma_arb.sv
// Per-word channel arbiter, combinational; SCU_DSP_DMA_RR_EN selects round-robin, else
// fixed priority (channel 0 first) with the current channel keeping the bus while lock is set.
module scu_dsp_dma_arb #(
  parameter int CHANNELS = 2,
  parameter int GW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] busy,
  input  logic [GW-1:0]       last,
  input  logic                lock,
  output logic [GW-1:0]       grant,
  output logic                valid
);

  assign valid = |busy;

`ifdef SCU_DSP_DMA_RR_EN
  // Rotate so that bit 0 is the channel just after the last grant.
  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [CHANNELS:0]     unused_rr;

  assign dbl       = {busy, busy} >> (int'(last) + 1);
  assign rot       = dbl[CHANNELS-1:0];
  assign unused_rr = {lock, dbl[2*CHANNELS-1:CHANNELS]};

  always_comb begin
    grant = last;
    for (int j = CHANNELS - 1; j >= 0; j--)
      if (rot[j]) grant = GW'((int'(last) + 1 + j) % CHANNELS);
  end
`else
  always_comb begin
    grant = '0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (busy[k]) grant = GW'(k);
    if (lock && busy[last]) grant = last;
  end
`endif

endmodule

// File: rtl/scu_dsp_dma_mc.sv
// Multi-channel DSP D0-bus DMA: one word per ARB+XFER pair, XFER held until DMA_ACK with CE.
// Arbitration mode is chosen by SCU_DSP_DMA_RR_EN (see scu_dsp_dma_arb).
module scu_dsp_dma_mc
  import scu_dsp_dma_mc_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int ADDR_W   = 27,
  parameter  int CNT_W    = 8,
  parameter  int BANKS    = 4,
  localparam int BW       = $clog2(BANKS),
  localparam int GW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic [CHANNELS-1:0]        ST,
  input  logic [CHANNELS-1:0]        ST_DIR,
  input  logic [CHANNELS-1:0]        ST_HOLD,
  input  logic [3*CHANNELS-1:0]      ST_ADDI,
  input  logic [BW*CHANNELS-1:0]     ST_BANK,
  input  logic [CNT_W*CHANNELS-1:0]  ST_CNT,
  input  logic [ADDR_W*CHANNELS-1:0] ST_ADDR,
  output logic [CHANNELS-1:0]        BUSY,
  output logic [CHANNELS-1:0]        DONE,
  output logic [ADDR_W*CHANNELS-1:0] CH_ADDR,
  output logic [ADDR_W-1:0]          DMA_A,
  output logic                       DMA_REQ,
  input  logic                       DMA_ACK,
  output logic                       DMA_WE,
  output logic [31:0]                DMA_DO,
  input  logic [31:0]                DMA_DI,
  output logic [BW-1:0]              RAM_BANK,
  output logic                       RAM_WE,
  output logic                       RAM_INC,
  output logic [31:0]                RAM_D,
  input  logic [31:0]                RAM_Q
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ARB  = ARB;
  localparam logic [1:0] S_XFER = XFER;

  logic [1:0]          state;
  DMACmd_t             cmd     [CHANNELS];
  logic [ADDR_W-1:0]   ch_addr [CHANNELS];
  logic [CHANNELS-1:0] busy, done, start, g_mask;
  logic [GW-1:0]       g, arb_grant;
  logic                arb_valid, cont, xfer_ack;
  logic [ADDR_W-1:0]   inc;

  // A channel that is busy or signalling DONE this cycle ignores its start strobe.
  assign start    = ST & ~busy & ~done & {CHANNELS{CE}};
  assign xfer_ack = (state == S_XFER) && DMA_ACK && CE;
  assign inc      = ADDR_W'(DMAAddrAdd(cmd[g].ADDI));
  assign g_mask   = CHANNELS'(1) << g;

  assign BUSY    = busy;
  assign DONE    = done;
  assign RAM_WE  = xfer_ack && !DMA_WE;
  assign RAM_INC = xfer_ack;
  assign RAM_D   = DMA_DI;
  assign DMA_DO  = RAM_Q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch_addr
    assign CH_ADDR[ADDR_W*gi +: ADDR_W] = ch_addr[gi];
  end

  scu_dsp_dma_arb #(.CHANNELS(CHANNELS), .GW(GW)) u_arb (
    .busy  (busy),
    .last  (g),
    .lock  (cont),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      busy     <= '0;
      done     <= '0;
      g        <= GW'(CHANNELS - 1);
      cont     <= 1'b0;
      DMA_A    <= '0;
      DMA_REQ  <= 1'b0;
      DMA_WE   <= 1'b0;
      RAM_BANK <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cmd[i]     <= '0;
        ch_addr[i] <= '0;
      end
    end else if (CE) begin
      done <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (start[i]) begin
          cmd[i] <= '{DIR:  ST_DIR[i],
                      HOLD: ST_HOLD[i],
                      ADDI: ST_ADDI[3*i +: 3],
                      BANK: CMD_BANK_W'(ST_BANK[BW*i +: BW]),
                      CNT:  (ST_CNT[CNT_W*i +: CNT_W] == '0) ? CMD_CNT_W'(1 << CNT_W)
                                                             : CMD_CNT_W'(ST_CNT[CNT_W*i +: CNT_W])};
          ch_addr[i] <= ST_ADDR[ADDR_W*i +: ADDR_W] & ~ADDR_W'(3);
          busy[i]    <= 1'b1;
        end
      end

      case (state)
        S_IDLE: if (|busy) state <= S_ARB;
        S_ARB: begin
          if (arb_valid) begin
            g <= arb_grant;
            // Continuing the same grant: DMA_A already advanced, which matters for HOLD channels.
            if (!(cont && arb_grant == g)) DMA_A <= ch_addr[arb_grant];
            DMA_WE   <= cmd[arb_grant].DIR;
            RAM_BANK <= BW'(cmd[arb_grant].BANK);
            DMA_REQ  <= 1'b1;
            state    <= S_XFER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_XFER: begin
          if (DMA_ACK) begin
            DMA_REQ    <= 1'b0;
            DMA_A      <= DMA_A + inc;
            cmd[g].CNT <= cmd[g].CNT - CMD_CNT_W'(1);
            if (!cmd[g].HOLD) ch_addr[g] <= ch_addr[g] + inc;
            if (cmd[g].CNT == CMD_CNT_W'(1)) begin
              busy[g] <= 1'b0;
              done[g] <= 1'b1;
              cont    <= 1'b0;
              state   <= (|(busy & ~g_mask)) ? S_ARB : S_IDLE;
            end else begin
              cont  <= 1'b1;
              state <= S_ARB;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
